// File: rtl/maxpool_layer_if.sv
// Stream and result bundle for maxpool_layer.
//   enable     run permission (starts a frame from idle, pauses filling when low)
//   in_valid   in_data holds a pixel
//   in_ready   stage accepts a pixel this cycle
//   in_data    signed pixel, raster order
//   frame_ack  consumer has read pool_out; releases the done state
//   done       pool_out holds a complete frame
//   pool_out   flat result, entry k at [k*DATA_W +: DATA_W], k = orow*OUT_DIM + ocol
// master = pixel producer / result consumer, slave = the pooling stage.
interface maxpool_layer_if #(
  parameter int DATA_W = 32,
  parameter int IN_DIM = 6
);
  localparam int OUT_DIM = IN_DIM / 2;

  logic                              enable;
  logic                              in_valid;
  logic                              in_ready;
  logic signed [DATA_W-1:0]          in_data;
  logic                              frame_ack;
  logic                              done;
  logic [OUT_DIM*OUT_DIM*DATA_W-1:0] pool_out;

  modport master (
    output enable, in_valid, in_data, frame_ack,
    input  in_ready, done, pool_out
  );

  modport slave (
    input  enable, in_valid, in_data, frame_ack,
    output in_ready, done, pool_out
  );
endinterface

// File: rtl/maxpool_layer.sv
// Streaming 2x2 / stride-2 signed max-pool stage.
// Takes one IN_DIM x IN_DIM feature map in raster order through bus.in_*,
// writes OUT_DIM x OUT_DIM maxima into bus.pool_out and holds bus.done
// until the consumer pulses bus.frame_ack.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    maxpool_layer_if.slave (enable, in_valid/in_ready/in_data,
//          frame_ack, done, pool_out)
// Optional build macro MAXPOOL_RELU_EN: clamp negative pixels to zero
// before they enter the compare tree.
module maxpool_layer #(
  parameter int DATA_W = 32,
  parameter int IN_DIM = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  maxpool_layer_if.slave bus
);
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int K       = OUT_DIM * OUT_DIM;
  localparam int CNT_W   = (IN_DIM > 2) ? $clog2(IN_DIM) : 1;
  localparam int OIDX_W  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int KIDX_W  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         row_q, row_d;
  logic [CNT_W-1:0]         col_q, col_d;
  logic signed [DATA_W-1:0] hreg_q, hreg_d;
  logic signed [DATA_W-1:0] lbuf_q [OUT_DIM];
  logic signed [DATA_W-1:0] lbuf_d [OUT_DIM];
  logic signed [DATA_W-1:0] pool_q [K];
  logic signed [DATA_W-1:0] pool_d [K];

  logic                     accept;
  logic                     last_px;
  logic signed [DATA_W-1:0] px;
  logic [OIDX_W-1:0]        lidx;
  logic [KIDX_W-1:0]        kidx;
  logic [K*DATA_W-1:0]      pool_flat;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

`ifdef MAXPOOL_RELU_EN
  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction
  assign px = relu(bus.in_data);
`else
  assign px = bus.in_data;
`endif

  assign bus.in_ready = (state_q == ST_FILL) && bus.enable;
  assign bus.done     = (state_q == ST_DONE);
  assign accept       = bus.in_ready && bus.in_valid;
  assign last_px      = (row_q == CNT_W'(IN_DIM-1)) && (col_q == CNT_W'(IN_DIM-1));
  // Output column pair and output entry addressed by the current pixel.
  assign lidx         = OIDX_W'(col_q >> 1);
  assign kidx         = KIDX_W'(row_q >> 1) * KIDX_W'(OUT_DIM) + KIDX_W'(col_q >> 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.enable) state_d = ST_FILL;
      ST_FILL: if (accept && last_px) state_d = ST_DONE;
      ST_DONE: if (bus.frame_ack) state_d = bus.enable ? ST_FILL : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Even rows build horizontal pair maxima into the line buffer; odd rows
  // fold the buffered pair into the lower pair and emit one result per
  // 2x2 window on the odd-column pixel.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    hreg_d = hreg_q;
    lbuf_d = lbuf_q;
    pool_d = pool_q;
    if (accept) begin
      unique case ({row_q[0], col_q[0]})
        2'b00:   hreg_d       = px;
        2'b01:   lbuf_d[lidx] = smax(hreg_q, px);
        2'b10:   hreg_d       = smax(lbuf_q[lidx], px);
        default: pool_d[kidx] = smax(hreg_q, px);
      endcase
      if (col_q == CNT_W'(IN_DIM-1)) begin
        col_d = '0;
        row_d = (row_q == CNT_W'(IN_DIM-1)) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pool_flat = '0;
    for (int k = 0; k < K; k++) pool_flat[k*DATA_W +: DATA_W] = pool_q[k];
  end
  assign bus.pool_out = pool_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      hreg_q  <= '0;
      for (int i = 0; i < OUT_DIM; i++) lbuf_q[i] <= '0;
      for (int k = 0; k < K; k++) pool_q[k] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      hreg_q  <= hreg_d;
      lbuf_q  <= lbuf_d;
      pool_q  <= pool_d;
    end
  end
endmodule

// File: tb/tb_maxpool_layer.sv
// Self-checking bench for maxpool_layer: randomized stimulus against a
// frame-level behavioural model, plus literal expectations per scenario.
module tb_maxpool_layer;
  localparam int DATA_W  = 32;
  localparam int IN_DIM  = 6;
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int K       = OUT_DIM * OUT_DIM;
  localparam int N       = IN_DIM * IN_DIM;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maxpool_layer_if #(.DATA_W(DATA_W), .IN_DIM(IN_DIM)) bus ();

  maxpool_layer #(.DATA_W(DATA_W), .IN_DIM(IN_DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [K*DATA_W-1:0] act, input logic [K*DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_FILL, M_DONE} mst_t;
  mst_t                     mst;
  logic signed [DATA_W-1:0] frame [N];
  int                       mcnt;
  logic [K*DATA_W-1:0]      mpool;

  function automatic logic signed [DATA_W-1:0] clamp(input logic signed [DATA_W-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [K*DATA_W-1:0] pool_of_frame();
    logic [K*DATA_W-1:0]      r;
    logic signed [DATA_W-1:0] m;
    r = '0;
    for (int orow = 0; orow < OUT_DIM; orow++)
      for (int ocol = 0; ocol < OUT_DIM; ocol++) begin
        m = frame[2*orow*IN_DIM + 2*ocol];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (frame[(2*orow+dr)*IN_DIM + 2*ocol + dc] > m)
              m = frame[(2*orow+dr)*IN_DIM + 2*ocol + dc];
        r[(orow*OUT_DIM + ocol)*DATA_W +: DATA_W] = m;
      end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst   = M_IDLE;
      mcnt  = 0;
      mpool = '0;
    end else begin
      case (mst)
        M_IDLE: if (bus.enable) mst = M_FILL;
        M_FILL: if (bus.enable && bus.in_valid) begin
          frame[mcnt] = clamp(bus.in_data);
          mcnt++;
          if (mcnt == N) begin
            mpool = pool_of_frame();
            mcnt  = 0;
            mst   = M_DONE;
          end
        end
        default: if (bus.frame_ack) mst = bus.enable ? M_FILL : M_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      chk("in_ready", bus.in_ready, (mst == M_FILL) && bus.enable);
      chk("done", bus.done, mst == M_DONE);
      if (mst == M_DONE) chk_vec("pool_out", bus.pool_out, mpool);
    end
  end

  // ---------------- stimulus ----------------
  logic signed [DATA_W-1:0] pix [N];

  // kind: 0 ramp 0..N-1, 1 -(i+1), 2 descending N-1..0, 3 random full range
  // vmode: 0 always valid, 1 toggle each cycle, 2 random
  task automatic drive_frame(input int kind, input int n_pix, input int vmode,
                             input bit pause, input bit ack_mid);
    int idx = 0;
    int cyc = 0;
    int pause_left = 0;
    bit paused = 1'b0;
    bit pend = 1'b0;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       pix[i] = DATA_W'(i);
        1:       pix[i] = -DATA_W'(i + 1);
        2:       pix[i] = DATA_W'(N - 1 - i);
        default: pix[i] = $urandom;
      endcase
    end
    while (idx < n_pix && cyc < 2000) begin
      @(negedge clk); #1;
      if (pend) idx++;
      pend = 1'b0;
      cyc++;
      bus.frame_ack = ack_mid && (idx == 20);
      if (idx == n_pix) begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
      end else begin
        if (pause && !paused && idx == 3*IN_DIM + 2) begin
          pause_left = 5;
          paused     = 1'b1;
        end
        if (pause_left > 0) begin
          bus.enable = 1'b0;
          pause_left--;
        end else begin
          bus.enable = 1'b1;
        end
        case (vmode)
          0:       bus.in_valid = 1'b1;
          1:       bus.in_valid = cyc[0];
          default: bus.in_valid = 1'($urandom_range(0, 1));
        endcase
        bus.in_data = pix[idx];
        #1;
        pend = bus.in_valid && bus.in_ready;
      end
    end
    bus.frame_ack = 1'b0;
    if (idx < n_pix) chk("drive_timeout", idx, n_pix);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    chk("done_reached", bus.done, 1);
  endtask

  task automatic ack(input bit en);
    @(negedge clk); #1;
    bus.frame_ack = 1'b1;
    bus.enable    = en;
    @(negedge clk); #1;
    bus.frame_ack = 1'b0;
  endtask

  task automatic chk_lit(input string name, input int exp [K]);
    for (int k = 0; k < K; k++)
      chk(name, $signed(bus.pool_out[k*DATA_W +: DATA_W]), exp[k]);
  endtask

  int exp_ramp [K] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
`ifdef MAXPOOL_RELU_EN
  int exp_neg  [K] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
  int exp_neg  [K] = '{-1, -3, -5, -13, -15, -17, -25, -27, -29};
`endif
  // Descending ramp: every window's maximum is its top-left pixel.
  int exp_desc [K] = '{35, 33, 31, 23, 21, 19, 11, 9, 7};

  initial begin
    bus.enable    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", bus.done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk_vec("rst_pool", bus.pool_out, '0);
    #1 rst_n = 1'b1;
    check_en = 1'b1;

    // Reset mid-frame after 10 pixels.
    drive_frame(0, 10, 0, 1'b0, 1'b0);
    chk("mid_pool0", $signed(bus.pool_out[0 +: DATA_W]), 7);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", bus.done, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk_vec("midrst_pool", bus.pool_out, '0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Ramp frame, continuous valid.
    drive_frame(0, N, 0, 1'b0, 1'b0);
    wait_done();
    chk_lit("ramp", exp_ramp);
    ack(1'b1);

    // Negative frame.
    drive_frame(1, N, 0, 1'b0, 1'b0);
    wait_done();
    chk_lit("neg", exp_neg);
    ack(1'b1);

    // Toggled valid plus an enable pause in row 3.
    drive_frame(0, N, 1, 1'b1, 1'b0);
    wait_done();
    chk_lit("stall", exp_ramp);
    ack(1'b1);

    // Random data, random valid.
    for (int f = 0; f < 3; f++) begin
      drive_frame(3, N, 2, 1'b1, 1'b0);
      wait_done();
      ack(1'b1);
    end

    // Done hold with spurious traffic, then a descending frame.
    drive_frame(0, N, 0, 1'b0, 1'b0);
    wait_done();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.enable   = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    chk("hold_done", bus.done, 1);
    chk_lit("hold", exp_ramp);
    ack(1'b1);
    chk("ack_fill_ready", bus.in_ready, 1);
    drive_frame(2, N, 0, 1'b0, 1'b0);
    wait_done();
    chk_lit("desc", exp_desc);

    // Ack with enable low returns to idle; stray acks are ignored.
    ack(1'b0);
    chk("idle_done", bus.done, 0);
    @(negedge clk); #1 bus.frame_ack = 1'b1;
    @(negedge clk); #1 bus.frame_ack = 1'b0;
    chk("idle_ack_done", bus.done, 0);
    chk("idle_ack_ready", bus.in_ready, 0);
    drive_frame(3, N, 2, 1'b0, 1'b1);
    wait_done();
    ack(1'b0);
    repeat (3) @(negedge clk);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
